// File: rtl/multicycle_adder.sv
// Multicycle adder/subtractor: adds CHUNK bits per cycle over N = WIDTH/CHUNK cycles.
// Ports: clk, rst (sync, active-high); in_valid/in_ready accept val_1, val_2, sub;
//        out_valid/out_ready return out, carry_out, overflow, zero (held until taken).
module multicycle_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] val_1,
    input  logic [WIDTH-1:0] val_2,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [CHUNK:0]   csum;
    logic [WIDTH-1:0] acc_next;
    logic             last;
    logic             msb_cin;

    always_comb begin
        csum = {1'b0, op_a[cnt*CHUNK +: CHUNK]}
             + {1'b0, op_b[cnt*CHUNK +: CHUNK]}
             + {{CHUNK{1'b0}}, carry};
        acc_next = acc;
        acc_next[cnt*CHUNK +: CHUNK] = csum[CHUNK-1:0];
        last = (cnt == LAST_CNT);
        // Sum bit = a ^ b ^ cin, so the carry into the MSB is recoverable
        // from the operand and result MSBs without a separate carry chain tap.
        msb_cin = op_a[WIDTH-1] ^ op_b[WIDTH-1] ^ acc_next[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            acc       <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a     <= val_1;
                        // Subtraction as a + ~b + 1: the +1 enters as carry-in.
                        op_b     <= sub ? ~val_2 : val_2;
                        carry    <= sub;
                        cnt      <= '0;
                        acc      <= '0;
                        in_ready <= 1'b0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    acc   <= acc_next;
                    carry <= csum[CHUNK];
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        out       <= acc_next;
                        carry_out <= csum[CHUNK];
                        overflow  <= msb_cin ^ csum[CHUNK];
                        zero      <= (acc_next == '0);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_adder.sv
// Testbench for multicycle_adder: directed, backpressure, reset, random
// back-to-back and parameter-sweep scenarios against a plain-arithmetic model.
module tb_multicycle_adder;

    typedef struct packed {
        logic [31:0] o;
        logic        c;
        logic        v;
        logic        z;
    } res_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] val_1;
    logic [31:0] val_2;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic        carry_out;
    logic        overflow;
    logic        zero;

    logic        s_in_valid;
    logic [31:0] s_a;
    logic [31:0] s_b;
    logic        s_sub;
    logic        s_out_ready;
    logic [2:0]  s_rdy;
    logic [2:0]  s_vld;
    logic [31:0] s1_out;
    logic [31:0] s2_out;
    logic [15:0] s3_out;
    logic [2:0]  s_c;
    logic [2:0]  s_v;
    logic [2:0]  s_z;

    int vectors;
    int miscompares;

    multicycle_adder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .val_1(val_1), .val_2(val_2), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .out(out), .carry_out(carry_out),
        .overflow(overflow), .zero(zero)
    );

    multicycle_adder #(.WIDTH(32), .CHUNK(32)) u_s1 (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_rdy[0]),
        .val_1(s_a), .val_2(s_b), .sub(s_sub), .out_valid(s_vld[0]),
        .out_ready(s_out_ready), .out(s1_out), .carry_out(s_c[0]),
        .overflow(s_v[0]), .zero(s_z[0])
    );

    multicycle_adder #(.WIDTH(32), .CHUNK(4)) u_s2 (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_rdy[1]),
        .val_1(s_a), .val_2(s_b), .sub(s_sub), .out_valid(s_vld[1]),
        .out_ready(s_out_ready), .out(s2_out), .carry_out(s_c[1]),
        .overflow(s_v[1]), .zero(s_z[1])
    );

    multicycle_adder #(.WIDTH(16), .CHUNK(8)) u_s3 (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_rdy[2]),
        .val_1(s_a[15:0]), .val_2(s_b[15:0]), .sub(s_sub), .out_valid(s_vld[2]),
        .out_ready(s_out_ready), .out(s3_out), .carry_out(s_c[2]),
        .overflow(s_v[2]), .zero(s_z[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: unsigned/signed integer arithmetic on w-bit values.
    function automatic res_t model(int w, logic [31:0] a, logic [31:0] b, logic s);
        longint full, half, ua, ub, sa, sb, r, u;
        res_t m;
        full = longint'(1) << w;
        half = full >> 1;
        ua = longint'(a) & (full - 1);
        ub = longint'(b) & (full - 1);
        sa = (ua >= half) ? ua - full : ua;
        sb = (ub >= half) ? ub - full : ub;
        r = s ? sa - sb : sa + sb;
        u = s ? ua - ub : ua + ub;
        m.o = 32'(u & (full - 1));
        m.c = s ? (ua >= ub) : (u >= full);
        m.v = (r >= half) || (r < -half);
        m.z = ((u & (full - 1)) == 0);
        return m;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one operation on the main DUT and wait (bounded) for out_valid.
    // lat = -1 on timeout; bad_ready set if in_ready was seen high while busy.
    task automatic start_and_wait(input logic [31:0] a, input logic [31:0] b,
                                  input logic s, input bit noise,
                                  output int lat, output bit bad_ready);
        int k;
        k = 0;
        while (!in_ready && k < 20) begin
            tick();
            k++;
        end
        val_1 = a;
        val_2 = b;
        sub = s;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        bad_ready = 1'b0;
        lat = 0;
        while (lat < 50) begin
            if (noise) begin
                in_valid = 1'($urandom);
                val_1 = $urandom;
                val_2 = $urandom;
                sub = 1'($urandom);
                out_ready = 1'($urandom);
            end
            tick();
            lat++;
            if (out_valid) break;
            if (in_ready) bad_ready = 1'b1;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        if (!out_valid) lat = -1;
    endtask

    task automatic handshake();
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        vectors++;
        if ({in_ready, out_valid, out, carry_out, overflow, zero} !== {2'b10, 35'h0}) begin
            miscompares++;
            $display("FAIL reset: got rdy=%b vld=%b out=%h c=%b v=%b z=%b, want rdy=1 vld=0 all 0",
                     in_ready, out_valid, out, carry_out, overflow, zero);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        logic [31:0] ta [4] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0005, 32'h8000_0000};
        logic [31:0] tb [4] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0007, 32'h0000_0001};
        logic        ts [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        res_t        te [4] = '{'{32'h8000_0000, 1'b0, 1'b1, 1'b0},
                                '{32'h0000_0000, 1'b1, 1'b0, 1'b1},
                                '{32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0},
                                '{32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0}};
        int lat;
        bit bad;
        for (int i = 0; i < 4; i++) begin
            start_and_wait(ta[i], tb[i], ts[i], 1'b0, lat, bad);
            vectors++;
            if (lat !== 4 || bad) begin
                miscompares++;
                $display("FAIL directed%0d latency: got %0d busy_ready=%b, want 4 busy_ready=0",
                         i, lat, bad);
            end
            vectors++;
            if ({out, carry_out, overflow, zero} !== te[i]) begin
                miscompares++;
                $display("FAIL directed%0d result: got %h c=%b v=%b z=%b, want %h c=%b v=%b z=%b",
                         i, out, carry_out, overflow, zero, te[i].o, te[i].c, te[i].v, te[i].z);
            end
            handshake();
            vectors++;
            if ({out_valid, in_ready, out, carry_out, overflow, zero} !== {2'b01, te[i]}) begin
                miscompares++;
                $display("FAIL directed%0d retire: got vld=%b rdy=%b out=%h, want vld=0 rdy=1 out=%h",
                         i, out_valid, in_ready, out, te[i].o);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b;
        res_t e;
        int lat;
        bit bad;
        int errs;
        a = $urandom;
        b = $urandom;
        e = model(32, a, b, 1'b0);
        start_and_wait(a, b, 1'b0, 1'b0, lat, bad);
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom);
            val_1 = $urandom;
            val_2 = $urandom;
            sub = 1'($urandom);
            tick();
            if ({out_valid, in_ready, out, carry_out, overflow, zero} !== {2'b10, e}) errs++;
        end
        vectors++;
        if (errs != 0) begin
            miscompares++;
            $display("FAIL backpressure hold: %0d unstable cycles, want 0 (out=%h want %h)",
                     errs, out, e.o);
        end
        handshake();
        vectors++;
        if ({out_valid, in_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL backpressure release: got vld=%b rdy=%b, want vld=0 rdy=1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        bit bad;
        bit seen;
        val_1 = 32'h1234_5678;
        val_2 = 32'h0000_0001;
        sub = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if ({in_ready, out_valid, out, carry_out, overflow, zero} !== {2'b10, 35'h0}) begin
            miscompares++;
            $display("FAIL reset_calc: got rdy=%b vld=%b out=%h c=%b v=%b z=%b, want rdy=1 vld=0 all 0",
                     in_ready, out_valid, out, carry_out, overflow, zero);
        end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL reset_calc abort: got out_valid=1 after reset, want never");
        end
        // Reset must win over a simultaneous in_valid.
        val_1 = 32'd9;
        val_2 = 32'd9;
        in_valid = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid || !in_ready) seen = 1'b1;
        end
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL reset_priority: got op started, want none");
        end
        // Reset in DONE with out_ready also high.
        start_and_wait(32'd100, 32'd23, 1'b0, 1'b0, lat, bad);
        rst = 1'b1;
        out_ready = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        vectors++;
        if ({in_ready, out_valid, out, carry_out, overflow, zero} !== {2'b10, 35'h0}) begin
            miscompares++;
            $display("FAIL reset_done: got rdy=%b vld=%b out=%h, want rdy=1 vld=0 out=0",
                     in_ready, out_valid, out);
        end
        start_and_wait(32'd3, 32'd4, 1'b0, 1'b0, lat, bad);
        vectors++;
        if (lat !== 4 || out !== 32'd7 || {carry_out, overflow, zero} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_recover: got lat=%0d out=%h, want lat=4 out=00000007",
                     lat, out);
        end
        handshake();
    endtask

    task automatic test_back_to_back_random();
        logic [31:0] a, b;
        logic s;
        res_t e;
        int lat;
        bit bad;
        for (int i = 0; i < 400; i++) begin
            a = pick();
            b = pick();
            s = 1'($urandom);
            e = model(32, a, b, s);
            start_and_wait(a, b, s, 1'b1, lat, bad);
            vectors++;
            if (lat !== 4 || bad || {out, carry_out, overflow, zero} !== e) begin
                miscompares++;
                $display("FAIL random%0d %h %s %h: got lat=%0d out=%h c=%b v=%b z=%b, want lat=4 out=%h c=%b v=%b z=%b",
                         i, a, s ? "-" : "+", b, lat, out, carry_out, overflow, zero,
                         e.o, e.c, e.v, e.z);
            end
            handshake();
            vectors++;
            if ({out_valid, in_ready, out} !== {2'b01, e.o}) begin
                miscompares++;
                $display("FAIL random%0d idle: got vld=%b rdy=%b out=%h, want vld=0 rdy=1 out=%h",
                         i, out_valid, in_ready, out, e.o);
            end
        end
    endtask

    task automatic test_sweep();
        int   nexp [3] = '{1, 8, 2};
        int   wexp [3] = '{32, 32, 16};
        int   lat [3];
        res_t got [3];
        res_t e;
        bit [2:0] seen;
        int k;
        for (int i = 0; i < 1000; i++) begin
            k = 0;
            while (!(&s_rdy) && k < 20) begin
                tick();
                k++;
            end
            s_a = $urandom;
            s_b = $urandom;
            s_sub = 1'($urandom);
            s_in_valid = 1'b1;
            tick();
            s_in_valid = 1'b0;
            seen = '0;
            lat = '{-1, -1, -1};
            for (int cyc = 1; cyc <= 20 && seen != 3'b111; cyc++) begin
                tick();
                for (int j = 0; j < 3; j++) begin
                    if (!seen[j] && s_vld[j]) begin
                        seen[j] = 1'b1;
                        lat[j] = cyc;
                        case (j)
                            0: got[j] = '{s1_out, s_c[0], s_v[0], s_z[0]};
                            1: got[j] = '{s2_out, s_c[1], s_v[1], s_z[1]};
                            default: got[j] = '{{16'h0, s3_out}, s_c[2], s_v[2], s_z[2]};
                        endcase
                    end
                end
            end
            for (int j = 0; j < 3; j++) begin
                e = model(wexp[j], s_a, s_b, s_sub);
                vectors++;
                if (lat[j] !== nexp[j] || got[j] !== e) begin
                    miscompares++;
                    $display("FAIL sweep%0d iter%0d: got lat=%0d res=%h, want lat=%0d res=%h",
                             j, i, lat[j], got[j], nexp[j], e);
                end
            end
            s_out_ready = 1'b1;
            tick();
            s_out_ready = 1'b0;
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        val_1 = '0;
        val_2 = '0;
        sub = 1'b0;
        out_ready = 1'b0;
        s_in_valid = 1'b0;
        s_a = '0;
        s_b = '0;
        s_sub = 1'b0;
        s_out_ready = 1'b0;
        repeat (3) tick();
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_back_to_back_random();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_adder.md
MULTICYCLE_ADDER -- requirements
Module: multicycle_adder

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits.
REQ-002 Parameter: CHUNK, default 8, bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK; N = WIDTH/CHUNK.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operands and mode valid this cycle.
REQ-006 in_ready  output  1  block can accept an operation.
REQ-007 val_1  input  WIDTH  first operand.
REQ-008 val_2  input  WIDTH  second operand.
REQ-009 sub  input  1  0 = val_1 + val_2; 1 = val_1 - val_2.
REQ-010 out_valid  output  1  result and flags valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 out  output  WIDTH  result, modulo 2^WIDTH.
REQ-013 carry_out  output  1  carry from bit WIDTH-1 (sub: 1 = no borrow).
REQ-014 overflow  output  1  two's-complement signed overflow.
REQ-015 zero  output  1  out == 0.

Function
REQ-016 FSM states SHALL be IDLE, CALC, DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; 0 in CALC and DONE.
REQ-018 IDLE: on in_valid && in_ready, latch val_1, val_2 (bitwise-inverted when sub=1), carry-in = sub, chunk counter = 0; go to CALC.
REQ-019 CALC: each cycle add chunk [counter*CHUNK +: CHUNK] of both latched operands plus running carry; store sum chunk and carry; increment counter.
REQ-020 After chunk N-1 is computed, go to DONE; out_valid SHALL rise exactly N cycles after the acceptance edge (4 for defaults; 1 when CHUNK = WIDTH).
REQ-021 DONE: out_valid = 1; out, carry_out, overflow, zero SHALL be held stable until out_valid && out_ready.
REQ-022 On out_valid && out_ready, go to IDLE next cycle; in_ready = 1 that cycle; a new operation is accepted no earlier.
REQ-023 overflow SHALL equal carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-024 zero SHALL be computed over the full final WIDTH-bit result, not per chunk.
REQ-025 in_valid, val_1, val_2, sub SHALL be ignored outside IDLE; changes during CALC/DONE SHALL not affect the result.
REQ-026 out_ready SHALL be ignored outside DONE.
REQ-027 out, carry_out, overflow, zero SHALL be don't-care-free: they SHALL retain the last completed result while out_valid = 0 (0 after reset).
REQ-028 Results SHALL be bit-identical to single-cycle (val_1 ± val_2) mod 2^WIDTH for all inputs.

Reset
REQ-029 rst = 1 at a rising edge SHALL force IDLE, counter = 0, in_ready = 1 after the edge, out_valid = 0, out = 0, carry_out = 0, overflow = 0, zero = 0.
REQ-030 rst during CALC or DONE SHALL abort the operation; no out_valid SHALL appear for it.
REQ-031 rst SHALL take priority over in_valid and out_ready in the same cycle.

Verification
REQ-032 Add, defaults: 0x7FFFFFFF + 0x00000001, out_ready = 1 -> out_valid 4 cycles after accept, out = 0x80000000, carry_out 0, overflow 1, zero 0.
REQ-033 Add wrap: 0xFFFFFFFF + 0x00000001 -> out = 0x00000000, carry_out 1, overflow 0, zero 1.
REQ-034 Sub: 5 - 7 -> out = 0xFFFFFFFE, carry_out 0, overflow 0, zero 0; sub 0x80000000 - 1 -> out = 0x7FFFFFFF, carry_out 1, overflow 1.
REQ-035 Backpressure: out_ready = 0 for 10 cycles in DONE, with val_1/val_2 toggling -> out and flags unchanged, in_ready 0; out_ready = 1 -> IDLE next cycle.
REQ-036 Reset mid-operation: assert rst 2 cycles after accept -> out_valid never rises, all outputs 0, in_ready 1; next operation 3 + 4 -> out = 7.
REQ-037 Parameter sweep: (WIDTH, CHUNK) = (32,32), (32,4), (16,8); 1000 random operands each against reference model -> zero mismatches, latency = N.
